// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and sign-extended immediate.
// Define DECODE_SCOREBOARD_EN to track in-flight destination registers and stall on hazards.
module decode_stage #(
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 16,
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32,
    parameter logic [2**OPC_W-1:0] NO_WB_MASK = 16'hC000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   reg1,
    output logic [REG_W-1:0]   reg2,
    output logic [REG_W-1:0]   dest_reg,
    output logic [XLEN-1:0]    imm,
    output logic               writes_dest,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_reg
);

    logic [OPC_W-1:0] opc_in;
    logic [REG_W-1:0] r1_in;
    logic [REG_W-1:0] r2_in;
    logic [REG_W-1:0] dst_in;
    logic [XLEN-1:0]  imm_in;
    logic             wd_in;
    logic             hazard;
    logic             accept;
    logic             fire;

    logic             out_valid_reg;
    logic [OPC_W-1:0] opcode_reg;
    logic [REG_W-1:0] reg1_reg;
    logic [REG_W-1:0] reg2_reg;
    logic [REG_W-1:0] dest_reg_reg;
    logic [XLEN-1:0]  imm_reg;
    logic             writes_dest_reg;

    // Field layout, MSB first: opcode | reg1 | reg2 | dest | immediate.
    assign opc_in = in_instr[INSTR_W-1 -: OPC_W];
    assign r1_in  = in_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign r2_in  = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign dst_in = in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
    assign imm_in = XLEN'($signed(in_instr[IMM_W-1:0]));
    assign wd_in  = ~NO_WB_MASK[opc_in];

    assign accept   = in_valid & in_ready;
    assign fire     = out_valid_reg & out_ready;
    assign in_ready = (~out_valid_reg | out_ready) & ~hazard;

`ifdef DECODE_SCOREBOARD_EN
    logic [2**REG_W-1:0] busy_reg;

    // Hazard looks only at registered busy bits, so a writeback unblocks one cycle later.
    assign hazard = busy_reg[r1_in] | busy_reg[r2_in] | (wd_in & busy_reg[dst_in]);

    generate
        for (genvar gi = 0; gi < 2**REG_W; gi++) begin : g_busy
            localparam logic [REG_W-1:0] IDX = REG_W'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else if (accept && wd_in && dst_in == IDX) begin
                    busy_reg[gi] <= 1'b1;
                end else if (wb_valid && wb_reg == IDX) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{wb_valid, wb_reg};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            opcode_reg      <= '0;
            reg1_reg        <= '0;
            reg2_reg        <= '0;
            dest_reg_reg    <= '0;
            imm_reg         <= '0;
            writes_dest_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            opcode_reg      <= opc_in;
            reg1_reg        <= r1_in;
            reg2_reg        <= r2_in;
            dest_reg_reg    <= dst_in;
            imm_reg         <= imm_in;
            writes_dest_reg <= wd_in;
        end else if (fire) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign opcode      = opcode_reg;
    assign reg1        = reg1_reg;
    assign reg2        = reg2_reg;
    assign dest_reg    = dest_reg_reg;
    assign imm         = imm_reg;
    assign writes_dest = writes_dest_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, streaming, backpressure, scoreboard hazards, async reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [3:0]  reg1;
    logic [3:0]  reg2;
    logic [3:0]  dest_reg;
    logic [31:0] imm;
    logic        writes_dest;
    logic        wb_valid;
    logic [3:0]  wb_reg;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .reg1(reg1), .reg2(reg2), .dest_reg(dest_reg),
        .imm(imm), .writes_dest(writes_dest),
        .wb_valid(wb_valid), .wb_reg(wb_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [3:0] r);
        wb_valid = 1'b1;
        wb_reg   = r;
        cyc();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_reg = '0;
        repeat (2) cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_writes_dest", 32'(writes_dest), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic decode
        in_instr = 32'h1234_8001; in_valid = 1'b1;
        #1 check("dec_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("dec_out_valid", 32'(out_valid), 32'd1);
        check("dec_opcode", 32'(opcode), 32'd1);
        check("dec_reg1", 32'(reg1), 32'd2);
        check("dec_reg2", 32'(reg2), 32'd3);
        check("dec_dest", 32'(dest_reg), 32'd4);
        check("dec_imm", imm, 32'hFFFF_8001);
        check("dec_writes_dest", 32'(writes_dest), 32'd1);
        out_ready = 1'b1;
        cyc();
        check("dec_drained", 32'(out_valid), 32'd0);
        retire(4'd4);

        // Four back-to-back instructions
        for (int k = 0; k < 4; k++) begin
            in_instr = {4'h2, 4'h0, 4'h0, 4'(8 + k), 16'(k * 3)};
            in_valid = 1'b1;
            #1 check("stream_in_ready", 32'(in_ready), 32'd1);
            cyc();
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_dest", 32'(dest_reg), 32'(8 + k));
            check("stream_imm", imm, 32'(k * 3));
        end
        in_valid = 1'b0;
        cyc();
        check("stream_drained", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) retire(4'(8 + k));

        // Backpressure: hold three cycles
        out_ready = 1'b0;
        in_instr = 32'h2567_7FFF; in_valid = 1'b1;
        cyc();
        in_instr = 32'h3001_0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_dest", 32'(dest_reg), 32'd7);
            check("bp_imm", imm, 32'h0000_7FFF);
            cyc();
        end
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_opcode", 32'(opcode), 32'd3);
        check("b2b_dest", 32'(dest_reg), 32'd1);
        check("b2b_imm", imm, 32'h0000_0002);
        cyc();
        check("b2b_drained", 32'(out_valid), 32'd0);
        retire(4'd7);
        retire(4'd1);

        // Opcode F never writes its destination
        in_instr = 32'hF0A0_0005; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("nowb_opcode", 32'(opcode), 32'hF);
        check("nowb_writes_dest", 32'(writes_dest), 32'd0);
        cyc();
        in_instr = 32'h1000_0000; in_valid = 1'b1;
        #1 check("nowb_no_busy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        cyc();

        // Dependent instruction after dest=5
        in_instr = 32'h1005_0000; in_valid = 1'b1;
        cyc();
        in_instr = 32'h1506_0000;
`ifdef DECODE_SCOREBOARD_EN
        check("sb_stall0", 32'(in_ready), 32'd0);
        cyc();
        check("sb_fired", 32'(out_valid), 32'd0);
        check("sb_stall1", 32'(in_ready), 32'd0);
        cyc();
        check("sb_stall2", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_reg = 4'd5;
        #1 check("sb_wb_same_cycle", 32'(in_ready), 32'd0);
        cyc();
        wb_valid = 1'b0;
        check("sb_after_wb", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("sb_accept_valid", 32'(out_valid), 32'd1);
        check("sb_accept_reg1", 32'(reg1), 32'd5);
        check("sb_accept_dest", 32'(dest_reg), 32'd6);
        // Set and clear of reg 5 in the same cycle
        in_instr = 32'h1005_0000; in_valid = 1'b1;
        wb_valid = 1'b1; wb_reg = 4'd5;
        #1 check("sb_set_clear_ready", 32'(in_ready), 32'd1);
        cyc();
        wb_valid = 1'b0;
        in_instr = 32'h1500_0000;
        #1 check("sb_set_wins", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        cyc();
`else
        #1 check("nosb_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("nosb_out_valid", 32'(out_valid), 32'd1);
        check("nosb_reg1", 32'(reg1), 32'd5);
        check("nosb_dest", 32'(dest_reg), 32'd6);
        cyc();
`endif

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_instr = 32'h1234_8001; in_valid = 1'b1;
        #1 check("ar_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_opcode", 32'(opcode), 32'd0);
        check("ar_dest", 32'(dest_reg), 32'd0);
        check("ar_imm", imm, 32'd0);
        check("ar_writes_dest", 32'(writes_dest), 32'd0);
        cyc();
        rst_n = 1'b1;
        in_instr = 32'h1500_0000;
        #1 check("ar_busy_cleared", 32'(in_ready), 32'd1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
